// File: rtl/width_16to8.sv
// Re-serialises 16-bit words into a byte stream: a small word FIFO feeds a
// three-state serialiser that presents bytes on a registered valid/ready output.
module width_16to8 #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [15:0]              data_in,
  output logic                     ready_in,
  output logic                     valid_out,
  output logic [7:0]               data_out,
  input  logic                     ready_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [1:0]               state_o
);
  localparam int AW = $clog2(DEPTH);

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; valid never depends on ready in the same cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   hold_q, hold_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          overflow_q, overflow_d;
  logic          full, empty, push, pop;
  logic [15:0]   head;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign push  = valid_in && !full;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          hold_d     = head;
          data_out_d = first_byte(head);
          state_d    = FIRST;
        end
      end
      FIRST: begin
        if (ready_out) begin
          data_out_d = second_byte(hold_q);
          state_d    = SECOND;
        end
      end
      SECOND: begin
        if (ready_out) begin
          if (!empty) begin
            pop        = 1'b1;
            hold_d     = head;
            data_out_d = first_byte(head);
            state_d    = FIRST;
          end else begin
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_out_d = (state_d != IDLE);
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d  = overflow_q | (valid_in && full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  assign ready_in   = !full;
  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign state_o    = state_q;

endmodule
